score_lives_controller: RTL and testbench
=========================================

# score_lives_controller

Game-state stage directly downstream of the collision controller. It converts the asteroid-destroyed and ship-hit collision pulses into a 4-digit BCD score, a lives count, and a play/respawn/game-over state machine. Its status outputs gate ship control and shot firing in the top level and feed the score display.

## Interface
Parameters:
- START_LIVES, 3: lives loaded on game start; legal range 1–7.
- ASTEROID_POINTS, 8'h10: BCD points added per destroyed asteroid; legal range 01–99 (two BCD digits).
- RESPAWN_CYCLES, 24'd100: number of `clk` cycles spent invulnerable after losing a life; must be ≥1.

Ports:
- clk, input, 1: system clock; every register is clocked on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: level input; a rising edge starts or restarts a game.
- asteroid_hit, input, 1: level input from the collision controller; one rising edge scores one asteroid.
- ship_hit, input, 1: level input; one rising edge costs one life.
- score_bcd, output, 16: four BCD digits, [15:12] is the most significant.
- lives, output, 3: remaining lives.
- playing, output, 1: high in PLAY and RESPAWN.
- invulnerable, output, 1: high in RESPAWN.
- game_over, output, 1: high in OVER.
- high_score_bcd, output, 16: best score so far (see Configuration).

## Operation
- Edge detection:
  - Each of start, asteroid_hit and ship_hit has a 1-bit delayed copy.
  - The event for an input is `in & ~in_q`. A held level produces exactly one event.
- States: IDLE, PLAY, RESPAWN, OVER. Reset enters IDLE.
- IDLE:
  - On a start event, go to PLAY, clear the score to 0000 and load lives with START_LIVES.
  - asteroid_hit and ship_hit are ignored.
- PLAY:
  - On a ship_hit event with lives > 1: decrement lives, load the respawn counter with RESPAWN_CYCLES-1, go to RESPAWN.
  - On a ship_hit event with lives == 1: set lives to 0, go to OVER.
- RESPAWN:
  - The counter decrements once per cycle. When it reaches 0 on a clock edge, go to PLAY.
  - ship_hit events are discarded.
- OVER:
  - A start event behaves exactly as in IDLE.
  - asteroid_hit and ship_hit are ignored.
- Scoring:
  - Active in PLAY and RESPAWN only.
  - On an asteroid_hit event, add ASTEROID_POINTS as a BCD add: per-digit adjust of +6 when a digit sum is >9, with carry rippling through all four digits.
  - The result saturates at 9999; the score never wraps.
- Simultaneous events in the same cycle:
  - asteroid_hit and ship_hit together: the asteroid scores and the life is also lost, including the PLAY→OVER case.
  - A start event in PLAY or RESPAWN is ignored.
- Reset during a game: all registers go to reset values immediately, regardless of clock.

## Timing
- Reset values:
  - state = IDLE, score_bcd = 16'h0000, lives = 0.
  - playing = invulnerable = game_over = 0.
  - high_score_bcd = 16'h0000.
  - Edge-detect registers = 0; respawn counter = 0.
- Latency: when an input is sampled high at clock edge N (after being low at N-1), the event is acted on at edge N. All outputs are registered and reflect it after edge N.
- RESPAWN duration: invulnerable stays high for exactly RESPAWN_CYCLES cycles.
- Throughput: one asteroid_hit event per 2 cycles at most, because the input must go low for a cycle between events.

## Configuration
- SCORE_HIGH_SCORE_EN defined:
  - A 16-bit high-score register is kept. It is cleared only by reset.
  - On the edge that enters OVER, if the final score (including any same-cycle asteroid points) is greater than the stored value, it is written to high_score_bcd.
- SCORE_HIGH_SCORE_EN undefined: the register is not built and high_score_bcd is tied to 16'h0000.

## Test plan
- Start and score: reset, start pulse, then 3 separate asteroid_hit pulses with ASTEROID_POINTS=8'h10 → score_bcd = 16'h0030, lives = 3, playing = 1.
- BCD carry and saturation: with ASTEROID_POINTS=8'h99, 101 hits → score_bcd = 16'h9999 (no wrap). With 8'h05 from 16'h0095, one hit → 16'h0100.
- Respawn window: with RESPAWN_CYCLES=4, a ship_hit pulse gives lives 3→2 and invulnerable = 1 for exactly 4 cycles. A second ship_hit pulse inside the window leaves lives = 2.
- Game over: lives = 1 with ship_hit and asteroid_hit rising in the same cycle → lives = 0, game_over = 1, the score includes the points, and (with the macro defined) high_score_bcd equals the score.
- Held input and ignored events: asteroid_hit held high for 50 cycles gives exactly one score increment. Hits in IDLE or OVER leave the score unchanged.
- Async reset mid-RESPAWN: assert reset_n low between clock edges → all outputs read zero before the next edge.

Source files
------------

// File: rtl/score_lives_controller.sv
// Game-state stage: turns collision pulses into a BCD score, a lives count and a play/respawn/over FSM.
// Optional macro SCORE_HIGH_SCORE_EN builds the high-score register; otherwise high_score_bcd is tied to zero.
module score_lives_controller #(
    parameter int unsigned START_LIVES     = 3,
    parameter logic [7:0]  ASTEROID_POINTS = 8'h10,
    parameter logic [23:0] RESPAWN_CYCLES  = 24'd100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        asteroid_hit,
    input  logic        ship_hit,
    output logic [15:0] score_bcd,
    output logic [2:0]  lives,
    output logic        playing,
    output logic        invulnerable,
    output logic        game_over,
    output logic [15:0] high_score_bcd
);

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned LIVES_W = 3;
    localparam int unsigned CNT_W   = 24;
    localparam logic [SCORE_W-1:0] ADDEND    = {8'h00, ASTEROID_POINTS};
    localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {IDLE, PLAY, RESPAWN, OVER} state_t;

    state_t             state;
    state_t             state_next;
    logic               start_q;
    logic               asteroid_q;
    logic               ship_q;
    logic [CNT_W-1:0]   respawn_cnt;
    logic               start_ev;
    logic               asteroid_ev;
    logic               ship_ev;
    logic [SCORE_W-1:0] score_sum_c;
    logic [SCORE_W-1:0] score_next_c;
    logic [4:0]         dsum;
    logic               carry;

    assign start_ev    = start & ~start_q;
    assign asteroid_ev = asteroid_hit & ~asteroid_q;
    assign ship_ev     = ship_hit & ~ship_q;

    // Saturating 4-digit BCD add; a carry out of the top digit means the true sum exceeds 9999.
    always_comb begin
        score_sum_c = '0;
        carry       = 1'b0;
        dsum        = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dsum = 5'(score_bcd[i*4 +: 4]) + 5'(ADDEND[i*4 +: 4]) + 5'(carry);
            if (dsum > 5'd9) begin
                dsum  = dsum + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            score_sum_c[i*4 +: 4] = dsum[3:0];
        end
        if (carry) begin
            score_sum_c = SCORE_MAX;
        end
    end

    assign score_next_c = (asteroid_ev && (state == PLAY || state == RESPAWN)) ? score_sum_c : score_bcd;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, OVER: if (start_ev) state_next = PLAY;
            PLAY:       if (ship_ev) state_next = (lives > 3'd1) ? RESPAWN : OVER;
            RESPAWN:    if (respawn_cnt == '0) state_next = PLAY;
            default:    state_next = IDLE;
        endcase
    end

    // State, status flags, score, lives and respawn timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            asteroid_q   <= 1'b0;
            ship_q       <= 1'b0;
            respawn_cnt  <= '0;
            score_bcd    <= '0;
            lives        <= '0;
            playing      <= 1'b0;
            invulnerable <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            start_q      <= start;
            asteroid_q   <= asteroid_hit;
            ship_q       <= ship_hit;
            state        <= state_next;
            playing      <= (state_next == PLAY) || (state_next == RESPAWN);
            invulnerable <= (state_next == RESPAWN);
            game_over    <= (state_next == OVER);
            case (state)
                IDLE, OVER: begin
                    if (start_ev) begin
                        score_bcd <= '0;
                        lives     <= LIVES_W'(START_LIVES);
                    end
                end
                PLAY: begin
                    score_bcd <= score_next_c;
                    if (ship_ev) begin
                        if (lives > 3'd1) begin
                            lives       <= lives - 3'd1;
                            respawn_cnt <= RESPAWN_CYCLES - CNT_W'(1);
                        end else begin
                            lives <= '0;
                        end
                    end
                end
                RESPAWN: begin
                    score_bcd <= score_next_c;
                    if (respawn_cnt != '0) respawn_cnt <= respawn_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SCORE_HIGH_SCORE_EN
    logic enter_over_c;
    assign enter_over_c = (state == PLAY) && (state_next == OVER);

    // Best final score, captured including any same-cycle asteroid points
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_score_bcd <= '0;
        end else if (enter_over_c && (score_next_c > high_score_bcd)) begin
            high_score_bcd <= score_next_c;
        end
    end
`else
    assign high_score_bcd = '0;
`endif

endmodule

// File: tb/tb_score_lives_controller.sv
// Randomized bench for score_lives_controller checked against a decimal-arithmetic game model.
module tb_score_lives_controller;

    localparam int unsigned LIVES0 = 3;
    localparam int          PTS    = 55;
    localparam int          RESP   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        asteroid_hit = 1'b0;
    logic        ship_hit = 1'b0;
    logic [15:0] score_bcd;
    logic [2:0]  lives;
    logic        playing;
    logic        invulnerable;
    logic        game_over;
    logic [15:0] high_score_bcd;

    int n_checks = 0;
    int n_fail   = 0;

    score_lives_controller #(
        .START_LIVES    (LIVES0),
        .ASTEROID_POINTS(8'h55),
        .RESPAWN_CYCLES (24'd4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .asteroid_hit  (asteroid_hit),
        .ship_hit      (ship_hit),
        .score_bcd     (score_bcd),
        .lives         (lives),
        .playing       (playing),
        .invulnerable  (invulnerable),
        .game_over     (game_over),
        .high_score_bcd(high_score_bcd)
    );

    always #5 clk = ~clk;

    // Game model: plain decimal score, remaining invulnerable cycles, spec-level modes
    typedef enum int {M_IDLE, M_PLAY, M_RESP, M_OVER} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_score = 0, m_lives = 0, m_inv = 0, m_hs = 0;
    bit    ps = 0, pa = 0, ph = 0, se, ae, he;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = M_IDLE; m_score = 0; m_lives = 0; m_inv = 0; m_hs = 0;
            ps = 0; pa = 0; ph = 0;
        end else begin
            se = start && !ps; ae = asteroid_hit && !pa; he = ship_hit && !ph;
            ps = start; pa = asteroid_hit; ph = ship_hit;
            if (m_mode == M_IDLE || m_mode == M_OVER) begin
                if (se) begin
                    m_mode = M_PLAY; m_score = 0; m_lives = LIVES0;
                end
            end else begin
                if (ae) m_score = (m_score + PTS > 9999) ? 9999 : m_score + PTS;
                if (m_mode == M_PLAY) begin
                    if (he && m_lives > 1) begin
                        m_lives--; m_mode = M_RESP; m_inv = RESP;
                    end else if (he) begin
                        m_lives = 0; m_mode = M_OVER;
`ifdef SCORE_HIGH_SCORE_EN
                        if (m_score > m_hs) m_hs = m_score;
`endif
                    end
                end else begin
                    m_inv--;
                    if (m_inv == 0) m_mode = M_PLAY;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n) begin
            chk("score", score_bcd, to_bcd(m_score));
            chk("lives", 16'(lives), 16'(m_lives));
            chk("playing", 16'(playing), 16'(m_mode == M_PLAY || m_mode == M_RESP));
            chk("invulnerable", 16'(invulnerable), 16'(m_mode == M_RESP));
            chk("game_over", 16'(game_over), 16'(m_mode == M_OVER));
            chk("high_score", high_score_bcd, to_bcd(m_hs));
        end
    end

    task automatic tick(input logic s, input logic a, input logic h);
        @(negedge clk);
        #1;
        start = s; asteroid_hit = a; ship_hit = h;
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0; start = 0; asteroid_hit = 0; ship_hit = 0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic pulse(input logic s, input logic a, input logic h);
        tick(s, a, h);
        tick(0, 0, 0);
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_score"}, score_bcd, 16'h0000);
        chk({tag, "_lives"}, 16'(lives), 16'h0000);
        chk({tag, "_flags"}, 16'({playing, invulnerable, game_over}), 16'h0000);
        chk({tag, "_hs"}, high_score_bcd, 16'h0000);
    endtask

    int inv_cnt;
    logic [15:0] exp_hs;

    initial begin
        do_reset();
        settle();
        zero_check("reset");

        // Hits in IDLE are ignored
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        settle();
        chk("idle_hits", score_bcd, 16'h0000);

        pulse(1, 0, 0);
        repeat (3) pulse(0, 1, 0);
        settle();
        chk("three_hits", score_bcd, 16'h0165);
        chk("three_lives", 16'(lives), 16'h0003);
        chk("three_playing", 16'(playing), 16'h0001);

        // Held level scores once
        repeat (50) tick(0, 1, 0);
        tick(0, 0, 0);
        settle();
        chk("held_hit", score_bcd, 16'h0220);

        // Respawn window with a second ship hit inside it
        tick(0, 0, 1);
        inv_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, i == 1);
            if (invulnerable) inv_cnt++;
        end
        chk("resp_len", 16'(inv_cnt), 16'(RESP));
        chk("resp_lives", 16'(lives), 16'h0002);

        // Random play
        do_reset();
        for (int i = 0; i < 3000; i++)
            tick(($urandom % 40) == 0, ($urandom % 3) == 0, ($urandom % 12) == 0);
        tick(0, 0, 0);

        // Saturation at 9999
        do_reset();
        pulse(1, 0, 0);
        repeat (185) pulse(0, 1, 0);
        settle();
        chk("saturate", score_bcd, 16'h9999);

        // Game over with simultaneous asteroid and ship hit
        do_reset();
        pulse(1, 0, 0);
        repeat (2) begin
            tick(0, 0, 1);
            repeat (6) tick(0, 0, 0);
        end
        chk("one_life", 16'(lives), 16'h0001);
        pulse(0, 1, 1);
        settle();
        chk("over_lives", 16'(lives), 16'h0000);
        chk("over_flag", 16'(game_over), 16'h0001);
        chk("over_score", score_bcd, 16'h0055);
`ifdef SCORE_HIGH_SCORE_EN
        exp_hs = 16'h0055;
`else
        exp_hs = 16'h0000;
`endif
        chk("over_hs", high_score_bcd, exp_hs);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        settle();
        chk("over_hits", score_bcd, 16'h0055);

        // Async reset in the middle of a respawn window
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        tick(0, 0, 1);
        tick(0, 0, 0);
        settle();
        chk("pre_reset_inv", 16'(invulnerable), 16'h0001);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 zero_check("async");
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) tick(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
